inst_fetch_responder: RTL

INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

---
 rtl/inst_fetch_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_responder.sv
// Direct-mapped instruction line buffer between IF and memory. Hits return the word combinationally.
// Latency: a hit answers in the same cycle. A miss answers the cycle after bus_ack.
// Backpressure: stall_request holds IF from the miss cycle through the bus_ack cycle. One bus read is outstanding at most.
module inst_fetch_responder #(
    parameter int INDEX_WIDTH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chip_enable,
    input  logic [31:0] address,
    input  logic        invalidate,
    output logic [31:0] instruction,
    output logic        stall_request,
    output logic        bus_request,
    output logic [31:0] bus_address,
    input  logic        bus_ack,
    input  logic [31:0] bus_data
);

    localparam int ENTRIES   = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, MISS_WAIT, DELIVER} state_t;

    state_t                 state;
    logic [ENTRIES-1:0]     valid;
    logic [TAG_WIDTH-1:0]   tags  [ENTRIES];
    logic [31:0]            words [ENTRIES];
    logic [31:0]            miss_address;
    logic [31:0]            fill_data;

    logic [INDEX_WIDTH-1:0] lookup_index;
    logic [TAG_WIDTH-1:0]   lookup_tag;
    logic [INDEX_WIDTH-1:0] fill_index;
    logic [TAG_WIDTH-1:0]   fill_tag;
    logic                   deliver_match;
    logic                   lookup_active;
    logic                   hit;
    logic                   miss;
    logic                   fill_now;
    logic                   unused_low_bits;

    assign lookup_index = address[INDEX_WIDTH+1:2];
    assign lookup_tag   = address[31:INDEX_WIDTH+2];
    assign fill_index   = miss_address[INDEX_WIDTH+1:2];
    assign fill_tag     = miss_address[31:INDEX_WIDTH+2];

    // Byte-offset bits never take part in a word fetch.
    assign unused_low_bits = ^{address[1:0], miss_address[1:0]};

    // DELIVER serves the just-filled word straight from fill_data, so the
    // result holds even when a coincident invalidate left the entry invalid.
    assign deliver_match = chip_enable && (state == DELIVER)
                           && (address[31:2] == miss_address[31:2]);
    assign lookup_active = chip_enable
                           && ((state == IDLE) || ((state == DELIVER) && !deliver_match));
    assign hit           = lookup_active && valid[lookup_index]
                           && (tags[lookup_index] == lookup_tag);
    assign miss          = lookup_active && !hit;
    assign fill_now      = (state == MISS_WAIT) && bus_ack;

    // Response to IF: a fill word, a buffer hit, or zero while stalled or idle.
    always_comb begin
        instruction   = 32'h0;
        stall_request = 1'b0;
        if (deliver_match) begin
            instruction = fill_data;
        end else if (hit) begin
            instruction = words[lookup_index];
        end
        if (miss || (chip_enable && (state == MISS_WAIT))) begin
            stall_request = 1'b1;
        end
    end

    assign bus_address = bus_request ? miss_address : 32'h0;

    // Control FSM: miss capture, bus handshake, valid bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            valid        <= '0;
            bus_request  <= 1'b0;
            miss_address <= 32'h0;
            fill_data    <= 32'h0;
        end else begin
            case (state)
                IDLE, DELIVER: begin
                    if (miss) begin
                        miss_address <= {address[31:2], 2'b00};
                        bus_request  <= 1'b1;
                        state        <= MISS_WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                MISS_WAIT: begin
                    if (bus_ack) begin
                        valid[fill_index] <= 1'b1;
                        fill_data         <= bus_data;
                        bus_request       <= 1'b0;
                        state             <= DELIVER;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so it overrides a coincident fill's valid bit.
            if (invalidate) begin
                valid <= '0;
            end
        end
    end

    // Buffer storage: words and tags need no reset, the valid bits guard them.
    always_ff @(posedge clock) begin
        if (reset && fill_now) begin
            words[fill_index] <= bus_data;
            tags[fill_index]  <= fill_tag;
        end
    end

endmodule
